// File: rtl/usb_hid_pkg.sv
// Shared types and constants for the USB HID keyboard event block.
// Contents: report byte positions, special keycodes, the event record
// pushed into the event FIFO, the scan FSM states, and a keycode helper.
package usb_hid_pkg;

  localparam int         MOD_BYTE         = 0;
  localparam int         KEY_BASE         = 2;
  localparam logic [7:0] KEY_ROLLOVER     = 8'h01;
  localparam logic [7:0] MOD_USAGE_BASE   = 8'hE0;
  // Codes 00..03 are "no key", rollover and error codes, never real keys
  localparam logic [7:0] KEY_LAST_SPECIAL = 8'h03;

  typedef struct packed {
    logic       press;
    logic [7:0] usage;
  } kbd_event_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    MOD     = 3'd2,
    BREAK   = 3'd3,
    MAKE    = 3'd4,
    COMMIT  = 3'd5
  } kbd_state_e;

  // True for keycodes that represent a real key and may produce an event
  function automatic logic key_emittable(input logic [7:0] key);
    return key > KEY_LAST_SPECIAL;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Ports: clk, reset_ni (async, active-low), push_i/data_i (write side),
// pop_i (read side, ignored when empty), data_o (head entry, zero when
// empty), valid_o (not empty), count_o (entries held), drop_o (a push was
// refused because the FIFO was full and nothing was popped that cycle).
module event_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Push/pop qualification; a pop frees the slot a same-cycle push needs
  always_comb begin
    do_pop_s  = pop_i && (count_q != {CW{1'b0}});
    do_push_s = push_i && ((count_q != FULL_COUNT) || do_pop_s);
    drop_o    = push_i && !do_push_s;
    wr_ptr_d  = do_push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign valid_o = (count_q != {CW{1'b0}});
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
  assign count_o = count_q;

endmodule

// File: rtl/usb_hid_kbd_events.sv
// Turns boot-protocol HID keyboard reports into key make/break events.
// Each accepted report is diffed against the previous one by a scan that
// visits the 8 modifier bits, then the previous key slots (releases), then
// the new key slots (presses), one index per cycle, pushing events into a
// FWFT FIFO that the SoC drains.
// Ports: clk, reset_ni (async, active-low), usb_report_i/usb_report_valid_i
// (report and 1-cycle strobe), event_o/event_valid_o/event_ready_i (event
// stream, {press, usage}), fifo_count_o (entries held), overflow_o (sticky
// drop flag) and overflow_clr_i (clears it; a same-cycle drop wins).
module usb_hid_kbd_events
  import usb_hid_pkg::*;
#(
  parameter int REPORT_NB_BYTES = 8,
  parameter int KEY_SLOTS       = REPORT_NB_BYTES - 2,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset_ni,
  input  logic [8*REPORT_NB_BYTES-1:0]  usb_report_i,
  input  logic                          usb_report_valid_i,
  output logic [8:0]                    event_o,
  output logic                          event_valid_o,
  input  logic                          event_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o,
  input  logic                          overflow_clr_i
);
  localparam int IDX_W = (KEY_SLOTS > 8) ? $clog2(KEY_SLOTS) : 3;

  kbd_state_e                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [7:0]                 cur_mod_q, cur_mod_d, prev_mod_q, prev_mod_d;
  logic [KEY_SLOTS-1:0][7:0]  cur_keys_q, cur_keys_d, prev_keys_q, prev_keys_d;
  logic [7:0]                 pend_mod_q, pend_mod_d;
  logic [KEY_SLOTS-1:0][7:0]  pend_keys_q, pend_keys_d;
  logic                       pend_valid_q, pend_valid_d;
  logic                       push_q, push_d;
  kbd_event_t                 push_data_q, push_data_d;
  logic                       overflow_q, overflow_d;

  logic [7:0]                 rpt_mod_s;
  logic [KEY_SLOTS-1:0][7:0]  rpt_keys_s;
  logic [7:0]                 nxt_mod_s;
  logic [KEY_SLOTS-1:0][7:0]  nxt_keys_s;
  kbd_state_e                 nxt_state_s;
  logic [7:0]                 brk_key_s, mk_key_s;
  logic                       brk_in_cur_s, brk_dup_s, mk_in_prev_s, mk_dup_s;
  logic                       rollover_s, fifo_drop_s;
  logic [2:0]                 mod_idx_s;
  logic                       unused_rsvd_s;

  // The reserved byte carries nothing for us
  assign unused_rsvd_s = ^usb_report_i[8*KEY_BASE-1:8*(MOD_BYTE+1)];
  assign mod_idx_s     = idx_q[2:0];

  // Split the incoming report and pick what the next scan should work on:
  // a report arriving right now is newer than anything parked in pending
  always_comb begin
    rpt_mod_s = usb_report_i[8*MOD_BYTE +: 8];
    for (int k = 0; k < KEY_SLOTS; k++) begin
      rpt_keys_s[k] = usb_report_i[8*(KEY_BASE+k) +: 8];
    end
    nxt_mod_s   = usb_report_valid_i ? rpt_mod_s  : pend_mod_q;
    nxt_keys_s  = usb_report_valid_i ? rpt_keys_s : pend_keys_q;
    nxt_state_s = (usb_report_valid_i || pend_valid_q) ? CAPTURE : IDLE;
  end

  // Slot comparators for the key slot currently indexed by the scan
  always_comb begin
    brk_key_s    = 8'h00;
    mk_key_s     = 8'h00;
    brk_in_cur_s = 1'b0;
    brk_dup_s    = 1'b0;
    mk_in_prev_s = 1'b0;
    mk_dup_s     = 1'b0;
    rollover_s   = 1'b1;
    for (int k = 0; k < KEY_SLOTS; k++) begin
      brk_key_s  = (idx_q == IDX_W'(k)) ? prev_keys_q[k] : brk_key_s;
      mk_key_s   = (idx_q == IDX_W'(k)) ? cur_keys_q[k]  : mk_key_s;
      rollover_s = rollover_s & (cur_keys_q[k] == KEY_ROLLOVER);
    end
    for (int k = 0; k < KEY_SLOTS; k++) begin
      brk_in_cur_s = brk_in_cur_s | (cur_keys_q[k] == brk_key_s);
      mk_in_prev_s = mk_in_prev_s | (prev_keys_q[k] == mk_key_s);
      // Only earlier slots count as duplicates, so the first copy still fires
      brk_dup_s = brk_dup_s | ((IDX_W'(k) < idx_q) && (prev_keys_q[k] == brk_key_s));
      mk_dup_s  = mk_dup_s  | ((IDX_W'(k) < idx_q) && (cur_keys_q[k]  == mk_key_s));
    end
  end

  // Scan FSM next-state, event generation and pending-report handling
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cur_mod_d     = cur_mod_q;
    cur_keys_d    = cur_keys_q;
    prev_mod_d    = prev_mod_q;
    prev_keys_d   = prev_keys_q;
    push_d        = 1'b0;
    push_data_d   = '0;
    // A strobe while busy parks the report; a later one overwrites it
    pend_mod_d    = (usb_report_valid_i && (state_q != IDLE)) ? rpt_mod_s  : pend_mod_q;
    pend_keys_d   = (usb_report_valid_i && (state_q != IDLE)) ? rpt_keys_s : pend_keys_q;
    pend_valid_d  = (usb_report_valid_i && (state_q != IDLE)) ? 1'b1       : pend_valid_q;
    overflow_d    = fifo_drop_s ? 1'b1 : (overflow_clr_i ? 1'b0 : overflow_q);
    case (state_q)
      IDLE: begin
        if (usb_report_valid_i) begin
          cur_mod_d  = rpt_mod_s;
          cur_keys_d = rpt_keys_s;
          state_d    = CAPTURE;
        end else begin
          state_d    = IDLE;
        end
      end
      CAPTURE: begin
        // A rollover report is dropped without touching prev
        if (rollover_s) begin
          cur_mod_d    = nxt_mod_s;
          cur_keys_d   = nxt_keys_s;
          pend_valid_d = 1'b0;
          state_d      = nxt_state_s;
        end else begin
          idx_d        = {IDX_W{1'b0}};
          state_d      = MOD;
        end
      end
      MOD: begin
        push_d            = prev_mod_q[mod_idx_s] != cur_mod_q[mod_idx_s];
        push_data_d.press = cur_mod_q[mod_idx_s];
        push_data_d.usage = MOD_USAGE_BASE + {5'b00000, mod_idx_s};
        if (mod_idx_s == 3'd7) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = BREAK;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      BREAK: begin
        push_d            = key_emittable(brk_key_s) && !brk_in_cur_s && !brk_dup_s;
        push_data_d.press = 1'b0;
        push_data_d.usage = brk_key_s;
        if (idx_q == IDX_W'(KEY_SLOTS-1)) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = MAKE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      MAKE: begin
        push_d            = key_emittable(mk_key_s) && !mk_in_prev_s && !mk_dup_s;
        push_data_d.press = 1'b1;
        push_data_d.usage = mk_key_s;
        if (idx_q == IDX_W'(KEY_SLOTS-1)) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = COMMIT;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      COMMIT: begin
        prev_mod_d   = cur_mod_q;
        prev_keys_d  = cur_keys_q;
        cur_mod_d    = nxt_mod_s;
        cur_keys_d   = nxt_keys_s;
        pend_valid_d = 1'b0;
        state_d      = nxt_state_s;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All scan state, the registered push request and the sticky overflow
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      idx_q        <= {IDX_W{1'b0}};
      cur_mod_q    <= 8'h00;
      cur_keys_q   <= '0;
      prev_mod_q   <= 8'h00;
      prev_keys_q  <= '0;
      pend_mod_q   <= 8'h00;
      pend_keys_q  <= '0;
      pend_valid_q <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cur_mod_q    <= cur_mod_d;
      cur_keys_q   <= cur_keys_d;
      prev_mod_q   <= prev_mod_d;
      prev_keys_q  <= prev_keys_d;
      pend_mod_q   <= pend_mod_d;
      pend_keys_q  <= pend_keys_d;
      pend_valid_q <= pend_valid_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      overflow_q   <= overflow_d;
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk      (clk),
    .reset_ni (reset_ni),
    .push_i   (push_q),
    .data_i   (push_data_q),
    .pop_i    (event_ready_i),
    .data_o   (event_o),
    .valid_o  (event_valid_o),
    .count_o  (fifo_count_o),
    .drop_o   (fifo_drop_s)
  );

  assign overflow_o = overflow_q;

endmodule
